// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pkg
// Description : Shared definitions for the keypad scanner. This package holds
//               the FSM state encoding, the special key codes, the column
//               reset pattern, and the row/column to key-code mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

  typedef logic [1:0] state_t;

  localparam state_t SCAN     = 2'd0;
  localparam state_t DEBOUNCE = 2'd1;
  localparam state_t HELD     = 2'd2;

  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_HASH  = 4'd11;
  localparam logic [2:0] COL_RESET = 3'b110;

  // Rows 0..2 carry digits 1..9 in reading order. The bottom row is '*', '0', '#'.
  function automatic logic [3:0] key_code(input logic [1:0] row_idx,
                                          input logic [1:0] col_idx);
    logic [3:0] code;
    if (row_idx == 2'd3) begin
      case (col_idx)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row_idx} * 4'd3) + {2'b00, col_idx} + 4'd1;
    end
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick.sv
`default_nettype none
// ============================================================================
// Module      : scan_tick
// Description : Free-running divider. It emits a one-clock tick every SCAN_DIV
//               clocks and can be shared by the display refresh logic.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               tick  - high for one clk when the divider wraps
// Revision    : 1.0 - initial release
// ============================================================================
module scan_tick #(
  parameter int SCAN_DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int              CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/key_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module      : key_matrix_scan
// Description : Scans and debounces the 3x4 keypad. It emits one key code per
//               press together with a one-clock valid strobe.
// Ports       : clk       - system clock
//               rst_n     - asynchronous active-low reset
//               key_row   - row returns, active-low, asynchronous
//               key_col   - column drive, one-hot active-low
//               key_data  - last accepted key code
//               key_valid - one-clk strobe on key_data update
//               key_held  - high while the accepted key stays pressed
// Options     : KEY_REPEAT_EN - when defined, key_valid is re-strobed every
//               REPEAT_CNT ticks while the key stays held
// Revision    : 1.0 - initial release
// ============================================================================
module key_matrix_scan
  import key_pkg::*;
#(
  parameter int SCAN_DIV     = 25000,
  parameter int DEBOUNCE_CNT = 20,
  parameter int REPEAT_CNT   = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic [3:0] key_data,
  output logic       key_valid,
  output logic       key_held
);

  localparam int            CNT_W    = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic             tick;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cand;
  logic             press;
  logic [1:0]       row_idx;
  logic [1:0]       col_idx;
  logic [3:0]       cur_code;
  logic             match;
  logic             repeat_fire;

  // Two-flop synchronizer. Idle rows read high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
    end
  end

  scan_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // A press is exactly one low row. Ghosting or multi-key patterns count as none.
  always_comb begin
    press   = 1'b0;
    row_idx = 2'd0;
    case (row_sync)
      4'b1110: begin press = 1'b1; row_idx = 2'd0; end
      4'b1101: begin press = 1'b1; row_idx = 2'd1; end
      4'b1011: begin press = 1'b1; row_idx = 2'd2; end
      4'b0111: begin press = 1'b1; row_idx = 2'd3; end
      default: begin press = 1'b0; row_idx = 2'd0; end
    endcase
  end

  always_comb begin
    case (key_col)
      3'b110:  col_idx = 2'd0;
      3'b101:  col_idx = 2'd1;
      3'b011:  col_idx = 2'd2;
      default: col_idx = 2'd0;
    endcase
  end

  assign cur_code = key_code(row_idx, col_idx);
  assign match    = press && (cur_code == cand);

`ifdef KEY_REPEAT_EN
  localparam int           REP_W    = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);

  logic [REP_W-1:0] rep_cnt;

  // The counter idles at zero outside HELD, so entering HELD always starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (state != HELD) begin
      rep_cnt <= '0;
    end else if (tick) begin
      if (!press || (rep_cnt == REP_LAST)) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + REP_W'(1);
      end
    end
  end

  assign repeat_fire = tick && (state == HELD) && press && (rep_cnt == REP_LAST);
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_CNT != 0);
  assign repeat_fire   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      key_col   <= COL_RESET;
      key_data  <= 4'd0;
      key_valid <= 1'b0;
      cand      <= 4'd0;
      cnt       <= '0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (press) begin
              cand  <= cur_code;
              cnt   <= '0;
              state <= DEBOUNCE;
            end else begin
              key_col <= {key_col[1:0], key_col[2]};
            end
          end
          DEBOUNCE: begin
            if (match) begin
              if (cnt == CNT_LAST) begin
                key_data  <= cand;
                key_valid <= 1'b1;
                cnt       <= '0;
                state     <= HELD;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              // Keep the frozen column. The next SCAN tick re-examines it
              // before rotation continues.
              cnt   <= '0;
              state <= SCAN;
            end
          end
          HELD: begin
            if (press) begin
              // A bounce during release restarts the release count but never
              // produces a new accept.
              cnt <= '0;
              if (repeat_fire) begin
                key_valid <= 1'b1;
              end
            end else if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= SCAN;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            cnt   <= '0;
            state <= SCAN;
          end
        endcase
      end
    end
  end

  assign key_held = (state == HELD);

endmodule
`default_nettype wire

// File: tb/tb_key_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_matrix_scan
// Description : Self-checking bench for key_matrix_scan. A keypad model turns
//               the pressed-key map into row returns for the driven column.
//               Expected key codes are queued when a press is applied and are
//               matched against every key_valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_matrix_scan;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_CNT   = 5;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [3:0] key_data;
  logic       key_valid;
  logic       key_held;

  logic [3:0][2:0] pm;          // pm[row][col] = 1 when that key is pressed
  logic [3:0]      sb[$];
  logic [3:0]      last_data;
  int              total;
  int              bad;

  key_matrix_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .REPEAT_CNT   (REPEAT_CNT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A row line is pulled low when any pressed key on it sits on a driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      key_row[r] = ~|(pm[r] & ~key_col);
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check the strobe/data contract at the negedge.
  task automatic step();
    logic [3:0] exp;
    @(negedge clk);
    if (!rst_n) begin
      last_data = 4'd0;
    end else if (key_valid) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL strobe_unexpected observed key_data=%0h expected no strobe", key_data);
      end
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check("strobe_data", {4'd0, key_data}, {4'd0, exp});
      end
      last_data = key_data;
    end else begin
      check("data_stable", {4'd0, key_data}, {4'd0, last_data});
    end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_held(input logic val, input int budget, input string tag);
    int n;
    n = 0;
    while (key_held !== val && n < budget) begin
      step();
      n++;
    end
    check(tag, {7'd0, key_held}, {7'd0, val});
  endtask

  initial begin
    int         n;
    logic [2:0] c0;
    total     = 0;
    bad       = 0;
    last_data = 4'd0;
    pm        = '0;
    rst_n     = 1'b0;

    // Reset values
    steps(3);
    check("rst_col",   {5'd0, key_col}, 8'h06);
    check("rst_data",  {4'd0, key_data}, 8'h00);
    check("rst_valid", {7'd0, key_valid}, 8'h00);
    check("rst_held",  {7'd0, key_held}, 8'h00);
    rst_n = 1'b1;
    steps(6);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("arst_col",  {5'd0, key_col}, 8'h06);
    check("arst_data", {4'd0, key_data}, 8'h00);
    check("arst_held", {7'd0, key_held}, 8'h00);
    step();
    rst_n = 1'b1;

    // Rotation 110 -> 101 -> 011, every SCAN_DIV clocks
    n = 0;
    while (key_col === 3'b110 && n < 10) begin step(); n++; end
    check("rot_first", {5'd0, key_col}, 8'h05);
    n = 0;
    while (key_col === 3'b101 && n < 10) begin step(); n++; end
    check("rot_second", {5'd0, key_col}, 8'h03);
    check("rot_period", 8'(n), 8'(SCAN_DIV));

    // Clean press of key 5
    pm[1][1] = 1'b1;
    sb.push_back(4'd5);
    wait_held(1'b1, 100, "k5_held");
    check("k5_data", {4'd0, key_data}, 8'h05);
    steps(40);
    check("k5_still_held", {7'd0, key_held}, 8'h01);
    pm = '0;
    wait_held(1'b0, 60, "k5_release");
    check("k5_sb", 8'(sb.size()), 8'h00);
    c0 = key_col;
    steps(SCAN_DIV);
    check("k5_rotate", {7'd0, key_col !== c0}, 8'h01);

    // Press glitch on key 3, followed by a stable press
    n = 0;
    while (key_col !== 3'b011 && n < 20) begin step(); n++; end
    pm[0][2] = 1'b1;
    steps(SCAN_DIV);
    pm[0][2] = 1'b0;
    steps(SCAN_DIV);
    pm[0][2] = 1'b1;
    sb.push_back(4'd3);
    wait_held(1'b1, 100, "k3_held");
    check("k3_data", {4'd0, key_data}, 8'h03);
    pm = '0;
    wait_held(1'b0, 60, "k3_release");

    // Two rows on column 0: ignored, scanning continues
    pm[0][0] = 1'b1;
    pm[2][0] = 1'b1;
    steps(40);
    check("multi_held", {7'd0, key_held}, 8'h00);
    c0 = key_col;
    steps(SCAN_DIV);
    check("multi_rotate", {7'd0, key_col !== c0}, 8'h01);
    pm = '0;
    pm[3][2] = 1'b1;
    sb.push_back(4'd11);
    wait_held(1'b1, 100, "hash_held");
    check("hash_data", {4'd0, key_data}, 8'h0b);
    pm = '0;
    wait_held(1'b0, 60, "hash_release");

    // Key 9 with bounce on release
    pm[2][2] = 1'b1;
    sb.push_back(4'd9);
    wait_held(1'b1, 100, "k9_held");
    check("k9_data", {4'd0, key_data}, 8'h09);
    for (int i = 0; i < 2; i++) begin
      pm[2][2] = 1'b0;
      steps(SCAN_DIV);
      pm[2][2] = 1'b1;
      steps(SCAN_DIV);
    end
    check("k9_bounce_held", {7'd0, key_held}, 8'h01);
    pm = '0;
    steps(8);
    check("k9_release_wait", {7'd0, key_held}, 8'h01);
    wait_held(1'b0, 30, "k9_release");
    check("k9_sb", 8'(sb.size()), 8'h00);

    // Long hold of key 1: 19 held ticks with the key down
    pm[0][0] = 1'b1;
    sb.push_back(4'd1);
`ifdef KEY_REPEAT_EN
    sb.push_back(4'd1);
    sb.push_back(4'd1);
    sb.push_back(4'd1);
`endif
    wait_held(1'b1, 100, "k1_held");
    steps(76);
    check("k1_data", {4'd0, key_data}, 8'h01);
    pm = '0;
    wait_held(1'b0, 60, "k1_release");
    check("k1_sb", 8'(sb.size()), 8'h00);

    // Reset while key 7 is held: the key is reported again after debounce
    pm[2][0] = 1'b1;
    sb.push_back(4'd7);
    wait_held(1'b1, 100, "k7_held");
    check("k7_data", {4'd0, key_data}, 8'h07);
    #2 rst_n = 1'b0;
    #1;
    check("k7_rst_held", {7'd0, key_held}, 8'h00);
    check("k7_rst_data", {4'd0, key_data}, 8'h00);
    sb.push_back(4'd7);
    step();
    rst_n = 1'b1;
    wait_held(1'b1, 100, "k7_reheld");
    check("k7_redata", {4'd0, key_data}, 8'h07);
    pm = '0;
    wait_held(1'b0, 60, "k7_release");

    steps(4);
    check("sb_final", 8'(sb.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
